obsidian_memory_stage: RTL
==========================

OBSIDIAN_MEMORY_STAGE -- requirements
Module: obsidian_memory_stage

Interface
REQ-001 Parameter: ADDR_BITS, default 6, data-memory word-address width (64 words x 32 bits).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 EX_MEM  input  107  pipeline register from execute stage, with these fields:
- [106] RegWrite, [105] MemtoReg, [104] Branch, [103] MemRead, [102] MemWrite
- [101:70] branch target, [69] Zero, [68:37] ALU result, [36:5] store data (R[m]), [4:0] Rd
REQ-005 MEM_WB  output  71  registered pipeline register to write-back, with these fields:
- [70] RegWrite, [69] MemtoReg, [68:37] memory read data, [36:5] ALU result, [4:0] Rd
REQ-006 PCSrc  output  1  registered branch-taken flag.
REQ-007 branch_target  output  32  registered branch address.
REQ-008 stall  output  1  registered; high means upstream shall hold EX_MEM unchanged at the next edge.

Function
REQ-009 The block SHALL contain a 2**ADDR_BITS x 32 data memory, addressed by ALU result [ADDR_BITS+1:2].
- Low two bits ignored; upper bits ignored, so addresses wrap modulo depth.
REQ-010 The block SHALL implement a two-state FSM: IDLE and LOAD_WAIT.
REQ-011 IDLE, MemRead=0, MemWrite=0: at the edge, MEM_WB SHALL load EX_MEM fields:
- RegWrite, MemtoReg, ALU result, Rd
- read data = 0
- latency 1 cycle.
REQ-012 IDLE, MemWrite=1: at the edge, store data SHALL be written to the addressed word, and MEM_WB SHALL update as in REQ-011.
REQ-013 MemWrite=1 with MemRead=1 SHALL be treated as a store only; no read and no stall.
REQ-014 IDLE, MemRead=1, MemWrite=0: at the edge, the block SHALL perform the following.
- Latch address, RegWrite, MemtoReg, ALU result and Rd.
- Go to LOAD_WAIT and set stall=1.
- Emit a bubble on MEM_WB: all 71 bits 0.
REQ-015 LOAD_WAIT: EX_MEM SHALL be ignored. At the edge, the block SHALL perform the following.
- Load MEM_WB with the latched fields and the memory word at the latched address.
- Go to IDLE and clear stall.
- Load-to-MEM_WB latency is 2 cycles.
REQ-016 In IDLE, PCSrc SHALL register Branch AND Zero, and branch_target SHALL register EX_MEM[101:70], every edge.
REQ-017 On the LOAD_WAIT edge, PCSrc SHALL be 0 and branch_target SHALL hold its value.
REQ-018 A store followed immediately by a load to the same address SHALL return the stored data.
REQ-019 Back-to-back loads SHALL each incur one stall cycle; there SHALL be no stall in any other case.
REQ-020 Memory reads SHALL be synchronous only; there is no combinational memory output path.

Reset
REQ-021 At an edge with reset=1, the block SHALL set MEM_WB=0, PCSrc=0, branch_target=0, stall=0 and state=IDLE.
REQ-022 Reset during LOAD_WAIT SHALL abort the load; no MEM_WB result is produced for it.
REQ-023 Reset SHALL NOT clear data-memory contents, and no write SHALL occur on a reset edge.
REQ-024 Reset SHALL take priority over all other inputs.

Verification
REQ-025 Reset 2 cycles, then EX_MEM=0 -> MEM_WB=0, PCSrc=0, stall=0.
REQ-026 Store then load:
- Store: MemWrite=1, ALU result=0x08, data=0xDEADBEEF.
- Next, load: MemRead=1, RegWrite=1, MemtoReg=1, ALU result=0x08, Rd=3.
- Required response: stall=1 for one cycle, bubble on MEM_WB, then MEM_WB[68:37]=0xDEADBEEF and Rd=3.
REQ-027 R-type: RegWrite=1, ALU result=0x1234, Rd=7 -> next cycle MEM_WB[70]=1, [36:5]=0x1234, [4:0]=7, stall=0.
REQ-028 Branch=1, Zero=1, target=0x40 -> PCSrc=1, branch_target=0x40. Then with Zero=0 -> PCSrc=0.
REQ-029 Wrap-around and priority checks:
- Store 0x5 to address 0x100 (ADDR_BITS=6), then load address 0x0 -> returns 0x5.
- MemRead=MemWrite=1 -> no stall.
REQ-030 Reset mid-load:
- Load issued, reset asserted during LOAD_WAIT -> MEM_WB=0, stall=0, state=IDLE.
- Previously stored memory data still readable afterwards.

Source files
------------

// File: rtl/obsidian_memory_stage.sv
// obsidian_memory_stage: data memory access stage of the pipeline.
// Loads take one stall cycle; stores and ALU ops pass straight through.
module obsidian_memory_stage #(
    parameter int ADDR_BITS = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [106:0] EX_MEM,
    output logic [70:0]  MEM_WB,
    output logic         PCSrc,
    output logic [31:0]  branch_target,
    output logic         stall
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t state, state_nxt;

    logic                 reg_write;
    logic                 memto_reg;
    logic                 branch;
    logic                 mem_read;
    logic                 mem_write;
    logic [31:0]          target;
    logic                 zero;
    logic [31:0]          alu;
    logic [31:0]          store_data;
    logic [4:0]           rd;
    logic [ADDR_BITS-1:0] addr;

    assign reg_write  = EX_MEM[106];
    assign memto_reg  = EX_MEM[105];
    assign branch     = EX_MEM[104];
    assign mem_read   = EX_MEM[103];
    assign mem_write  = EX_MEM[102];
    assign target     = EX_MEM[101:70];
    assign zero       = EX_MEM[69];
    assign alu        = EX_MEM[68:37];
    assign store_data = EX_MEM[36:5];
    assign rd         = EX_MEM[4:0];
    assign addr       = alu[ADDR_BITS+1:2];

    logic [31:0]          mem [DEPTH];

    logic                 lat_rw;
    logic                 lat_mtr;
    logic [31:0]          lat_alu;
    logic [4:0]           lat_rd;
    logic [ADDR_BITS-1:0] lat_addr;

    logic [70:0]          mem_wb_nxt;
    logic                 pcsrc_nxt;
    logic [31:0]          bt_nxt;
    logic                 stall_nxt;
    logic                 we;
    logic                 latch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            MEM_WB        <= '0;
            PCSrc         <= 1'b0;
            branch_target <= '0;
            stall         <= 1'b0;
        end else begin
            state         <= state_nxt;
            MEM_WB        <= mem_wb_nxt;
            PCSrc         <= pcsrc_nxt;
            branch_target <= bt_nxt;
            stall         <= stall_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_wb_nxt = MEM_WB;
        pcsrc_nxt  = PCSrc;
        bt_nxt     = branch_target;
        stall_nxt  = 1'b0;
        we         = 1'b0;
        latch      = 1'b0;
        unique case (state)
            IDLE: begin
                pcsrc_nxt = branch & zero;
                bt_nxt    = target;
                // A store wins over a simultaneous read request.
                if (mem_read && !mem_write) begin
                    state_nxt  = LOAD_WAIT;
                    stall_nxt  = 1'b1;
                    latch      = 1'b1;
                    mem_wb_nxt = '0;
                end else begin
                    we         = mem_write & ~reset;
                    mem_wb_nxt = {reg_write, memto_reg, 32'h0, alu, rd};
                end
            end
            LOAD_WAIT: begin
                state_nxt  = IDLE;
                pcsrc_nxt  = 1'b0;
                mem_wb_nxt = {lat_rw, lat_mtr, mem[lat_addr],
                              lat_alu, lat_rd};
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            lat_rw   <= reg_write;
            lat_mtr  <= memto_reg;
            lat_alu  <= alu;
            lat_rd   <= rd;
            lat_addr <= addr;
        end
    end

    // No reset: memory contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= store_data;
        end
    end

endmodule
